// File: rtl/tf_gen_ctrl.sv
// tf_gen_ctrl: sequencer for a twiddle-factor generator.
//
// For each of num_stage stages it issues one seed cycle (LOAD, tf_wen=1),
// then IT_DEPTH generate iterations (GEN, tf_ren=1). Each iteration lasts
// MUL_LAT cycles, matching the multiplier latency. The last cycle of an
// iteration presents tf_valid, and it stalls until the consumer raises
// tf_ready. A single done pulse closes the run.
//
// Ports:
//   clk, rst       - clock (rising edge); asynchronous active-high reset
//   start          - launch request, honoured only in IDLE
//   num_stage[3:0] - stage count, latched at launch (0 goes straight to DONE)
//   abort          - synchronous cancel from any non-IDLE state
//   tf_ready       - consumer accepts the current twiddle set
//   tf_wen, tf_ren - seed strobe / generate enable to the generator
//   it_depth_cnt   - current iteration depth (zero-extended)
//   l              - current stage index (zero-extended)
//   tf_idx         - l*IT_DEPTH + it_depth_cnt
//   tf_valid       - generator outputs valid this cycle
//   busy, done     - run in progress / one-cycle completion pulse
module tf_gen_ctrl #(
  parameter int D_WIDTH  = 64,
  parameter int IT_DEPTH = 3,
  parameter int MUL_LAT  = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [3:0]         num_stage,
  input  logic               abort,
  input  logic               tf_ready,
  output logic               tf_wen,
  output logic               tf_ren,
  output logic [D_WIDTH-1:0] it_depth_cnt,
  output logic [D_WIDTH-1:0] l,
  output logic [D_WIDTH-1:0] tf_idx,
  output logic               tf_valid,
  output logic               busy,
  output logic               done
);

  localparam int DEPTH_W = (IT_DEPTH > 1) ? $clog2(IT_DEPTH) : 1;
  localparam int WAIT_W  = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [DEPTH_W-1:0] DEPTH_LAST = DEPTH_W'(IT_DEPTH - 1);
  localparam logic [WAIT_W-1:0]  WAIT_LAST  = WAIT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, GEN, DONE} state_t;

  state_t               state_reg, state_next;
  logic [3:0]           nstage_reg, nstage_next;
  logic [3:0]           stage_reg, stage_next;
  logic [DEPTH_W-1:0]   depth_reg, depth_next;
  logic [WAIT_W-1:0]    wcnt_reg, wcnt_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      nstage_reg <= '0;
      stage_reg  <= '0;
      depth_reg  <= '0;
      wcnt_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      nstage_reg <= nstage_next;
      stage_reg  <= stage_next;
      depth_reg  <= depth_next;
      wcnt_reg   <= wcnt_next;
    end
  end

  // Counters are cleared on every entry to IDLE and DONE, so the index
  // outputs are naturally zero there without extra output gating.
  always_comb begin
    state_next  = state_reg;
    nstage_next = nstage_reg;
    stage_next  = stage_reg;
    depth_next  = depth_reg;
    wcnt_next   = wcnt_reg;

    case (state_reg)
      IDLE: begin
        if (start && !abort) begin
          nstage_next = num_stage;
          stage_next  = '0;
          depth_next  = '0;
          wcnt_next   = '0;
          state_next  = (num_stage == 4'd0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        wcnt_next  = '0;
        state_next = GEN;
      end
      GEN: begin
        if (wcnt_reg != WAIT_LAST) begin
          wcnt_next = wcnt_reg + WAIT_W'(1);
        end else if (tf_ready) begin
          // Transfer accepted: move to the next depth, stage, or finish.
          wcnt_next = '0;
          if (depth_reg != DEPTH_LAST) begin
            depth_next = depth_reg + DEPTH_W'(1);
          end else if (stage_reg + 4'd1 < nstage_reg) begin
            stage_next = stage_reg + 4'd1;
            depth_next = '0;
            state_next = LOAD;
          end else begin
            stage_next = '0;
            depth_next = '0;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        stage_next = '0;
        depth_next = '0;
        wcnt_next  = '0;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Cancel overrides every transition above, including a pending transfer.
    if (abort && (state_reg != IDLE)) begin
      state_next = IDLE;
      stage_next = '0;
      depth_next = '0;
      wcnt_next  = '0;
    end
  end

  assign tf_wen       = (state_reg == LOAD);
  assign tf_ren       = (state_reg == GEN);
  assign tf_valid     = (state_reg == GEN) && (wcnt_reg == WAIT_LAST);
  assign busy         = (state_reg != IDLE);
  assign done         = (state_reg == DONE);
  assign it_depth_cnt = D_WIDTH'(depth_reg);
  assign l            = D_WIDTH'(stage_reg);
  assign tf_idx       = l * D_WIDTH'(IT_DEPTH) + it_depth_cnt;

endmodule

// File: tb/tb_tf_gen_ctrl.sv
// tb_tf_gen_ctrl: scoreboard bench for tf_gen_ctrl (default parameters).
// The stimulus process pushes hand-computed expected events (LOAD, transfer,
// stalled-valid, DONE) with the cycle they must appear in. A monitor samples
// on the falling edge, pops one entry per event the DUT shows and compares.
module tb_tf_gen_ctrl;

  localparam int K_LOAD  = 0;
  localparam int K_XFER  = 1;
  localparam int K_STALL = 2;
  localparam int K_DONE  = 3;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  num_stage;
  logic        abort;
  logic        tf_ready;
  logic        tf_wen;
  logic        tf_ren;
  logic [63:0] it_depth_cnt;
  logic [63:0] l;
  logic [63:0] tf_idx;
  logic        tf_valid;
  logic        busy;
  logic        done;

  tf_gen_ctrl #(.D_WIDTH(64), .IT_DEPTH(3), .MUL_LAT(2)) dut (
    .clk(clk), .rst(rst), .start(start), .num_stage(num_stage),
    .abort(abort), .tf_ready(tf_ready), .tf_wen(tf_wen), .tf_ren(tf_ren),
    .it_depth_cnt(it_depth_cnt), .l(l), .tf_idx(tf_idx),
    .tf_valid(tf_valid), .busy(busy), .done(done)
  );

  typedef struct {
    int          kind;
    int          cyc;
    longint unsigned el;
    longint unsigned ed;
    longint unsigned ei;
  } ev_t;

  ev_t exp_q[$];
  int  tests;
  int  fails;
  int  cyc;

  logic [196:0] outs;
  assign outs = {tf_wen, tf_ren, tf_valid, busy, done, it_depth_cnt, l, tf_idx};

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic ev(input int c0, input int off, input int lim, input int kind,
                    input int el, input int ed, input int ei);
    ev_t e;
    if (off <= lim) begin
      e.kind = kind; e.cyc = c0 + off;
      e.el = longint'(el); e.ed = longint'(ed); e.ei = longint'(ei);
      exp_q.push_back(e);
    end
  endtask

  // Two-stage run with tf_ready high, offsets relative to the start cycle.
  task automatic push_nominal(input int c0, input int lim);
    ev(c0,  1, lim, K_LOAD, 0, 0, 0);
    ev(c0,  3, lim, K_XFER, 0, 0, 0);
    ev(c0,  5, lim, K_XFER, 0, 1, 1);
    ev(c0,  7, lim, K_XFER, 0, 2, 2);
    ev(c0,  8, lim, K_LOAD, 1, 0, 3);
    ev(c0, 10, lim, K_XFER, 1, 0, 3);
    ev(c0, 12, lim, K_XFER, 1, 1, 4);
    ev(c0, 14, lim, K_XFER, 1, 2, 5);
    ev(c0, 15, lim, K_DONE, 0, 0, 0);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 256'(exp_q.size()), 256'(0));
    exp_q.delete();
    repeat (3) tick();
    check({name, "_idle"}, 256'(outs), 256'(0));
  endtask

  // Monitor: one line per observed transaction.
  always @(negedge clk) begin
    int  kind;
    ev_t e;
    if (!rst) begin
      kind = -1;
      if (done)          kind = K_DONE;
      else if (tf_wen)   kind = K_LOAD;
      else if (tf_valid) kind = tf_ready ? K_XFER : K_STALL;
      if (kind >= 0) begin
        $display("[TB] cyc %0d kind %0d l=%0d depth=%0d idx=%0d", cyc, kind, l, it_depth_cnt, tf_idx);
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_event: got kind %0d at cyc %0d, required none", kind, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event",
                256'({4'(kind), 32'(cyc), outs}),
                256'({4'(e.kind), 32'(e.cyc),
                      (e.kind == K_LOAD), (e.kind == K_XFER || e.kind == K_STALL),
                      (e.kind == K_XFER || e.kind == K_STALL), 1'b1, (e.kind == K_DONE),
                      64'(e.ed), 64'(e.el), 64'(e.ei)}));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0;
    rst = 1'b1; start = 1'b0; num_stage = 4'd0; abort = 1'b0; tf_ready = 1'b1;
    repeat (2) tick();
    check("reset_outputs", 256'(outs), 256'(0));
    rst = 1'b0;
    tick();

    // Nominal run; num_stage changes mid-run must not matter.
    c0 = cyc; num_stage = 4'd2; start = 1'b1;
    push_nominal(c0, 99);
    tick(); start = 1'b0;
    wait_until(c0 + 3); num_stage = 4'd5;
    drain("nominal", 40);

    // Stall: tf_ready low in cycles 5..7.
    c0 = cyc; num_stage = 4'd2; start = 1'b1;
    ev(c0,  1, 99, K_LOAD,  0, 0, 0);
    ev(c0,  3, 99, K_XFER,  0, 0, 0);
    ev(c0,  5, 99, K_STALL, 0, 1, 1);
    ev(c0,  6, 99, K_STALL, 0, 1, 1);
    ev(c0,  7, 99, K_STALL, 0, 1, 1);
    ev(c0,  8, 99, K_XFER,  0, 1, 1);
    ev(c0, 10, 99, K_XFER,  0, 2, 2);
    ev(c0, 11, 99, K_LOAD,  1, 0, 3);
    ev(c0, 13, 99, K_XFER,  1, 0, 3);
    ev(c0, 15, 99, K_XFER,  1, 1, 4);
    ev(c0, 17, 99, K_XFER,  1, 2, 5);
    ev(c0, 18, 99, K_DONE,  0, 0, 0);
    tick(); start = 1'b0;
    wait_until(c0 + 5); tf_ready = 1'b0;
    wait_until(c0 + 8); tf_ready = 1'b1;
    drain("stall", 40);

    // Zero stages: done the next cycle, no LOAD or GEN.
    c0 = cyc; num_stage = 4'd0; start = 1'b1;
    ev(c0, 1, 99, K_DONE, 0, 0, 0);
    tick(); start = 1'b0;
    drain("zero", 10);

    // Abort and start together in IDLE: no launch.
    num_stage = 4'd2; start = 1'b1; abort = 1'b1;
    tick(); start = 1'b0; abort = 1'b0;
    drain("abort_start", 2);

    // Abort in cycle 6, relaunch in cycle 8.
    c0 = cyc; num_stage = 4'd2; start = 1'b1;
    push_nominal(c0, 5);
    tick(); start = 1'b0;
    wait_until(c0 + 6); abort = 1'b1;
    tick(); abort = 1'b0;
    #3;
    check("abort_idle", 256'(outs), 256'(0));
    wait_until(c0 + 8); start = 1'b1;
    push_nominal(c0 + 8, 99);
    tick(); start = 1'b0;
    drain("abort_rerun", 40);

    // Asynchronous reset mid-cycle during GEN stage 1.
    c0 = cyc; num_stage = 4'd2; start = 1'b1;
    push_nominal(c0, 10);
    tick(); start = 1'b0;
    wait_until(c0 + 11);
    #2 rst = 1'b1;
    #1;
    check("async_reset", 256'(outs), 256'(0));
    check("reset_queue", 256'(exp_q.size()), 256'(0));
    rst = 1'b0;
    tick();
    c0 = cyc; start = 1'b1;
    push_nominal(c0, 99);
    tick(); start = 1'b0;
    drain("post_reset", 40);

    // start held high across a run: relaunch only from IDLE after DONE.
    c0 = cyc; num_stage = 4'd2; start = 1'b1;
    push_nominal(c0, 99);
    push_nominal(c0 + 16, 99);
    wait_until(c0 + 17); start = 1'b0;
    drain("held_start", 60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
